// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and stream-format constants for the program loader
package imem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_FLUSH, S_DONE, S_ERROR} loader_state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_ADDR_SHIFT = 2;
endpackage

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: byte stream input and instruction memory write port
interface imem_program_loader_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic [7:0] byte_data_i;
  logic byte_valid_i;
  logic byte_ready_o;
  logic write_en_o;
  logic [ADDR_WIDTH-1:0] write_address_o;
  logic [DATA_WIDTH-1:0] write_data_o;
  modport master(input byte_data_i, byte_valid_i, output byte_ready_o, write_en_o, write_address_o, write_data_o);
  modport slave(output byte_data_i, byte_valid_i, input byte_ready_o, write_en_o, write_address_o, write_data_o);
endinterface

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs little-endian bytes into 32-bit words
module imem_word_assembler import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);
  logic [23:0] r_bytes;
  logic [1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_bytes <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_bytes <= {i_byte, r_bytes[23:8]};
      r_cnt <= r_cnt + 2'd1;
    end
  end
  // Word includes the byte being accepted, so it is ready on the 4th transfer itself
  assign o_word = {i_byte, r_bytes};
  assign o_complete = i_shift && r_cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: loads a length-prefixed byte stream into instruction memory, holding the core in reset
module imem_program_loader import imem_loader_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  imem_program_loader_if.master bus,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_written_o
);
  loader_state_t r_state, w_next;
  logic [15:0] r_n, r_words, w_hdr;
  logic r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic w_xfer, w_start, w_shift, w_complete;
  logic [31:0] w_word;
  assign bus.byte_ready_o = r_state == S_HDR_LO || r_state == S_HDR_HI || r_state == S_DATA;
  assign w_xfer = bus.byte_valid_i && bus.byte_ready_o;
  assign w_start = start_i && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_shift = r_state == S_DATA && w_xfer;
  assign w_hdr = {bus.byte_data_i, r_n[7:0]};
  imem_word_assembler u_asm (
    .clk(clk), .rst(rst), .i_clear(w_start), .i_shift(w_shift),
    .i_byte(bus.byte_data_i), .o_word(w_word), .o_complete(w_complete)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_next = start_i ? S_HDR_LO : r_state;
      S_HDR_LO: w_next = w_xfer ? S_HDR_HI : r_state;
      S_HDR_HI: w_next = !w_xfer ? r_state : w_hdr == 16'd0 ? S_DONE : w_hdr > 16'(DEPTH_WORDS) ? S_ERROR : S_DATA;
      S_DATA: w_next = (w_complete && r_words == r_n - 16'd1) ? S_FLUSH : r_state;
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n <= '0;
      r_words <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      r_we <= 1'b0;
      if (w_start) begin
        r_n <= '0;
        r_words <= '0;
      end
      if (r_state == S_HDR_LO && w_xfer) r_n[7:0] <= bus.byte_data_i;
      if (r_state == S_HDR_HI && w_xfer) r_n[15:8] <= bus.byte_data_i;
      if (w_complete) begin
        r_we <= 1'b1;
        r_addr <= ADDR_WIDTH'(r_words) << WORD_ADDR_SHIFT;
        r_data <= DATA_WIDTH'(w_word);
        r_words <= r_words + 16'd1;
      end
    end
  end
  assign bus.write_en_o = r_we;
  assign bus.write_address_o = r_addr;
  assign bus.write_data_o = r_data;
  assign words_written_o = r_words;
  assign core_reset_o = r_state != S_DONE;
  assign done_o = r_state == S_DONE;
  assign error_o = r_state == S_ERROR;
endmodule
